axi_ar_burst_beat_gen: RTL and testbench

//  Read-address burst expander for the AXI-to-memory path; sits directly downstream of the AR-channel

---
 rtl/axi_ar_beat_pkg.sv | 31 +++
 rtl/axi_beat_addr_calc.sv | 48 ++++
 rtl/axi_ar_burst_beat_gen.sv | 144 ++++++++++++++
 tb/tb_axi_ar_burst_beat_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ar_beat_pkg.sv
// Shared types and helpers for the AXI AR burst beat generator.
// Holds the AR burst encodings, the FSM state type and the size clamp helper.
package axi_ar_beat_pkg;

  // AXI AR burst type encodings; 2'b11 is reserved and handled like INCR.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  // Beat generator FSM states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Limits a requested beat size to the memory data width:
  // min(size, log2(data_width/8)).
  function automatic logic [2:0] clamp_size(input logic [2:0] size,
                                            input int unsigned data_width);
    logic [2:0] max_size;
    max_size = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) <= data_width) max_size = 3'(i);
    end
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_beat_addr_calc.sv
// Combinational next-beat address for an AXI burst.
// FIXED repeats the address, INCR steps from the aligned address, WRAP stays
// inside a (len+1)*step container; illegal WRAP lengths and reserved bursts act as INCR.
module axi_beat_addr_calc
  import axi_ar_beat_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           size_i,
  input  logic [7:0]           len_i,
  input  burst_e               burst_i,
  output logic [AddrWidth-1:0] next_addr_o
);

  logic [AddrWidth-1:0] step;
  logic [AddrWidth-1:0] incr_addr;
  logic [AddrWidth-1:0] wrap_mask;
  logic [AddrWidth-1:0] wrap_addr;
  logic [2:0]           wrap_shift;
  logic                 wrap_legal;

  // Compute the INCR and WRAP candidates and select by burst type.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wrap_legal = 1'b1;
    wrap_shift = 3'd0;
    case (len_i)
      8'd1:    wrap_shift = 3'd1;
      8'd3:    wrap_shift = 3'd2;
      8'd7:    wrap_shift = 3'd3;
      8'd15:   wrap_shift = 3'd4;
      default: wrap_legal = 1'b0;
    endcase

    step      = AddrWidth'(1) << size_i;
    incr_addr = (addr_i & ~(step - AddrWidth'(1))) + step;
    wrap_mask = (step << wrap_shift) - AddrWidth'(1);
    wrap_addr = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);

    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = wrap_legal ? wrap_addr : incr_addr;
      default:     next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_ar_burst_beat_gen.sv
// AXI read-address burst expander: accepts one AR burst and emits one memory
// request per beat over a valid/ready handshake. All request outputs are registered.
// Optional feature: define AXI_AR_BEAT_GEN_BACK2BACK_EN to accept the next burst
// while the last beat of the current one is handshaking (no idle bubble).
module axi_ar_burst_beat_gen
  import axi_ar_beat_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic [2:0]           ar_size_i,
  input  logic [1:0]           ar_burst_i,
  input  logic [UserWidth-1:0] ar_user_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic [IdWidth-1:0]   req_id_o,
  output logic [2:0]           req_size_o,
  output logic [UserWidth-1:0] req_user_o,
  output logic                 req_last_o
);

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [2:0]           size_q, size_d;
  logic [UserWidth-1:0] user_q, user_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  burst_e               burst_q, burst_d;

  logic                 ar_hs;
  logic                 beat_hs;
  logic [AddrWidth-1:0] next_addr;

  assign beat_hs = valid_q & req_ready_i;
  assign ar_hs   = ar_valid_i & ar_ready_o;

`ifdef AXI_AR_BEAT_GEN_BACK2BACK_EN
  // Accept in IDLE, or in BURST while the final beat is leaving.
  assign ar_ready_o = (state_q == IDLE) | ((state_q == BURST) & beat_hs & last_q);
`else
  // Accept only in IDLE; consecutive bursts are separated by one idle cycle.
  assign ar_ready_o = (state_q == IDLE);
`endif

  axi_beat_addr_calc #(
    .AddrWidth (AddrWidth)
  ) u_addr_calc (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Next-state logic: advance beats on handshake, capture a new burst on AR handshake.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    addr_d  = addr_q;
    id_d    = id_q;
    size_d  = size_q;
    user_d  = user_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;

    if ((state_q == BURST) && beat_hs) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        addr_d = next_addr;
        cnt_d  = cnt_q + 8'd1;
        last_d = ((cnt_q + 8'd1) == len_q);
      end
    end

    // A capture overrides the end-of-burst return to IDLE (back-to-back case).
    if (ar_hs) begin
      state_d = BURST;
      valid_d = 1'b1;
      last_d  = (ar_len_i == 8'd0);
      addr_d  = ar_addr_i;
      id_d    = ar_id_i;
      size_d  = clamp_size(ar_size_i, DataWidth);
      user_d  = ar_user_i;
      len_d   = ar_len_i;
      cnt_d   = 8'd0;
      burst_d = burst_e'(ar_burst_i);
    end
  end

  // State and registered request outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the payload registers are reset too so req_* read as zero out of reset, not X.
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      size_q  <= 3'd0;
      user_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      burst_q <= BURST_FIXED;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      size_q  <= size_d;
      user_q  <= user_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
    end
  end

  assign req_valid_o = valid_q;
  assign req_last_o  = last_q;
  assign req_addr_o  = addr_q;
  assign req_id_o    = id_q;
  assign req_size_o  = size_q;
  assign req_user_o  = user_q;

endmodule

// File: tb/tb_axi_ar_burst_beat_gen.sv
// Scoreboard bench for axi_ar_burst_beat_gen: directed AR bursts push hand-computed
// beats into a queue; a monitor pops and compares on every request handshake.
module tb_axi_ar_burst_beat_gen;

`ifdef AXI_AR_BEAT_GEN_BACK2BACK_EN
  localparam int ExpGap = 1;
`else
  localparam int ExpGap = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ar_valid;
  logic        ar_ready_o;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [0:0]  ar_user;
  logic        req_valid_o;
  logic        req_ready;
  logic [31:0] req_addr_o;
  logic [3:0]  req_id_o;
  logic [2:0]  req_size_o;
  logic [0:0]  req_user_o;
  logic        req_last_o;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  size;
    logic        user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  axi_ar_burst_beat_gen #(
    .AddrWidth (32),
    .IdWidth   (4),
    .UserWidth (1),
    .DataWidth (64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ar_valid_i  (ar_valid),
    .ar_ready_o  (ar_ready_o),
    .ar_id_i     (ar_id),
    .ar_addr_i   (ar_addr),
    .ar_len_i    (ar_len),
    .ar_size_i   (ar_size),
    .ar_burst_i  (ar_burst),
    .ar_user_i   (ar_user),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready),
    .req_addr_o  (req_addr_o),
    .req_id_o    (req_id_o),
    .req_size_o  (req_size_o),
    .req_user_o  (req_user_o),
    .req_last_o  (req_last_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                      input logic user, input logic last);
    beat_t b;
    b.addr = addr; b.id = id; b.size = size; b.user = user; b.last = last;
    exp_q.push_back(b);
  endtask

  // Drive one AR burst; returns the cycle index of the accepting edge's preceding negedge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic user,
                         output int hs_cyc);
    int n = 0;
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
    ar_size = size; ar_burst = burst; ar_user = user;
    do begin
      @(negedge clk);
      n++;
    end while (!ar_ready_o && n < 50);
    if (!ar_ready_o) check("ar_accept_timeout", 32'(ar_ready_o), 32'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each handshaken beat with the scoreboard head; check hold under backpressure.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_valid_o && req_ready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%0h with no beat expected", req_addr_o);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", req_addr_o, e.addr);
          check("beat_id", 32'(req_id_o), 32'(e.id));
          check("beat_size", 32'(req_size_o), 32'(e.size));
          check("beat_user", 32'(req_user_o), 32'(e.user));
          check("beat_last", 32'(req_last_o), 32'(e.last));
        end
      end else if (rst_n && req_valid_o && !req_ready && exp_q.size() > 0) begin
        check("hold_addr", req_addr_o, exp_q[0].addr);
        check("hold_last", 32'(req_last_o), 32'(exp_q[0].last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  ar_cyc;
    int  ar_cyc2;
    bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset held with a pending AR: nothing may be emitted.
    ar_valid = 1'b1; ar_id = 4'hF; ar_addr = 32'hFFFF_0000; ar_len = 8'd3;
    ar_size = 3'd2; ar_burst = 2'b01; ar_user = 1'b1; req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(req_valid_o), 32'd0);
    check("rst_req_last", 32'(req_last_o), 32'd0);
    check("rst_req_addr", req_addr_o, 32'd0);
    check("rst_req_id", 32'(req_id_o), 32'd0);
    check("rst_req_size", 32'(req_size_o), 32'd0);
    ar_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready_after_rst", 32'(ar_ready_o), 32'd1);
    check("req_valid_after_rst", 32'(req_valid_o), 32'd0);
    @(posedge clk);
    #1;

    // INCR with unaligned start.
    push(32'h1003, 4'h1, 3'd2, 1'b0, 1'b0);
    push(32'h1004, 4'h1, 3'd2, 1'b0, 1'b0);
    push(32'h1008, 4'h1, 3'd2, 1'b0, 1'b0);
    push(32'h100C, 4'h1, 3'd2, 1'b0, 1'b1);
    beat_cyc.delete();
    send_ar(4'h1, 32'h1003, 8'd3, 3'd2, 2'b01, 1'b0, ar_cyc);
    drain();
    check("incr_beat_count", 32'(beat_cyc.size()), 32'd4);
    if (beat_cyc.size() == 4) begin
      check("incr_first_latency", 32'(beat_cyc[0] - ar_cyc), 32'd1);
      check("incr_beat_rate", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
    end

    // WRAP len=3 size=3: 32-byte container.
    push(32'h38, 4'h2, 3'd3, 1'b1, 1'b0);
    push(32'h20, 4'h2, 3'd3, 1'b1, 1'b0);
    push(32'h28, 4'h2, 3'd3, 1'b1, 1'b0);
    push(32'h30, 4'h2, 3'd3, 1'b1, 1'b1);
    send_ar(4'h2, 32'h38, 8'd3, 3'd3, 2'b10, 1'b1, ar_cyc);
    drain();

    // FIXED: same address every beat.
    push(32'h40, 4'h3, 3'd2, 1'b0, 1'b0);
    push(32'h40, 4'h3, 3'd2, 1'b0, 1'b0);
    push(32'h40, 4'h3, 3'd2, 1'b0, 1'b1);
    send_ar(4'h3, 32'h40, 8'd2, 3'd2, 2'b00, 1'b0, ar_cyc);
    drain();

    // WRAP with illegal len=2 behaves as INCR.
    push(32'h38, 4'h4, 3'd3, 1'b0, 1'b0);
    push(32'h40, 4'h4, 3'd3, 1'b0, 1'b0);
    push(32'h48, 4'h4, 3'd3, 1'b0, 1'b1);
    send_ar(4'h4, 32'h38, 8'd2, 3'd3, 2'b10, 1'b0, ar_cyc);
    drain();

    // Reserved burst code behaves as INCR.
    push(32'h10, 4'h5, 3'd2, 1'b1, 1'b0);
    push(32'h14, 4'h5, 3'd2, 1'b1, 1'b1);
    send_ar(4'h5, 32'h10, 8'd1, 3'd2, 2'b11, 1'b1, ar_cyc);
    drain();

    // Size clamped to log2(64/8)=3.
    push(32'h0, 4'h6, 3'd3, 1'b0, 1'b0);
    push(32'h8, 4'h6, 3'd3, 1'b0, 1'b1);
    send_ar(4'h6, 32'h0, 8'd1, 3'd5, 2'b01, 1'b0, ar_cyc);
    drain();

    // INCR wraps silently at the top of the address space.
    push(32'hFFFF_FFF8, 4'h7, 3'd3, 1'b0, 1'b0);
    push(32'h0000_0000, 4'h7, 3'd3, 1'b0, 1'b1);
    send_ar(4'h7, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0, ar_cyc);
    drain();

    // Backpressure mid-burst: ready 1,0,0,1,1,1.
    push(32'h2000, 4'h8, 3'd2, 1'b1, 1'b0);
    push(32'h2004, 4'h8, 3'd2, 1'b1, 1'b0);
    push(32'h2008, 4'h8, 3'd2, 1'b1, 1'b0);
    push(32'h200C, 4'h8, 3'd2, 1'b1, 1'b1);
    beat_cyc.delete();
    send_ar(4'h8, 32'h2000, 8'd3, 3'd2, 2'b01, 1'b1, ar_cyc);
    for (int i = 0; i < 6; i++) begin
      req_ready = pat[i];
      @(posedge clk);
      #1;
    end
    req_ready = 1'b1;
    drain();
    check("bp_beat_count", 32'(beat_cyc.size()), 32'd4);

    // Two single-beat bursts issued back to back.
    push(32'h100, 4'h9, 3'd3, 1'b0, 1'b1);
    push(32'h200, 4'hA, 3'd3, 1'b1, 1'b1);
    beat_cyc.delete();
    send_ar(4'h9, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0, ar_cyc);
    send_ar(4'hA, 32'h200, 8'd0, 3'd3, 2'b01, 1'b1, ar_cyc2);
    drain();
    check("b2b_beat_count", 32'(beat_cyc.size()), 32'd2);
    if (beat_cyc.size() == 2) begin
      check("b2b_beat_gap", 32'(beat_cyc[1] - beat_cyc[0]), 32'(ExpGap));
      check("b2b_ar_gap", 32'(ar_cyc2 - ar_cyc), 32'(ExpGap));
    end

    // Reset mid-burst drops the remaining beats.
    req_ready = 1'b0;
    send_ar(4'hB, 32'h3000, 8'd7, 3'd2, 2'b01, 1'b0, ar_cyc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req_valid", 32'(req_valid_o), 32'd0);
    check("abort_req_last", 32'(req_last_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_beats", 32'(req_valid_o), 32'd0);
    check("abort_ar_ready", 32'(ar_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
